// File: rtl/e203_dtcm_ram_arb_if.sv
// DTCM arbiter bundle: two requester command/response channels, the SRAM macro pins and light-sleep enable.
// slave = arbiter view, master = requester/SRAM side view.
interface e203_dtcm_ram_arb_if #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          ls_en;

    logic          a_cmd_valid;
    logic          a_cmd_ready;
    logic          a_cmd_read;
    logic [AW-1:0] a_cmd_addr;
    logic [DW-1:0] a_cmd_wdata;
    logic [MW-1:0] a_cmd_wmask;
    logic          a_rsp_valid;
    logic          a_rsp_ready;
    logic [DW-1:0] a_rsp_rdata;

    logic          b_cmd_valid;
    logic          b_cmd_ready;
    logic          b_cmd_read;
    logic [AW-1:0] b_cmd_addr;
    logic [DW-1:0] b_cmd_wdata;
    logic [MW-1:0] b_cmd_wmask;
    logic          b_rsp_valid;
    logic          b_rsp_ready;
    logic [DW-1:0] b_rsp_rdata;

    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_ls;

    modport slave (
        input  ls_en,
        input  a_cmd_valid, a_cmd_read, a_cmd_addr, a_cmd_wdata, a_cmd_wmask, a_rsp_ready,
        output a_cmd_ready, a_rsp_valid, a_rsp_rdata,
        input  b_cmd_valid, b_cmd_read, b_cmd_addr, b_cmd_wdata, b_cmd_wmask, b_rsp_ready,
        output b_cmd_ready, b_rsp_valid, b_rsp_rdata,
        output ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_ls,
        input  ram_dout
    );

    modport master (
        output ls_en,
        output a_cmd_valid, a_cmd_read, a_cmd_addr, a_cmd_wdata, a_cmd_wmask, a_rsp_ready,
        input  a_cmd_ready, a_rsp_valid, a_rsp_rdata,
        output b_cmd_valid, b_cmd_read, b_cmd_addr, b_cmd_wdata, b_cmd_wmask, b_rsp_ready,
        input  b_cmd_ready, b_rsp_valid, b_rsp_rdata,
        input  ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_ls,
        output ram_dout
    );
endinterface

// File: rtl/e203_dtcm_ram_arb.sv
// Two-port arbiter for the single-port DTCM SRAM: A has priority, B is forced through after STARVE_MAX losses.
// Grant is combinational; response appears the next cycle and is held until accepted (one outstanding per port).

module e203_dtcm_ram_arb_rsp_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant,
    input  logic          grant_read,
    input  logic [DW-1:0] ram_dout,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          free
);
    logic          vld_q,   vld_d;
    logic          fresh_q, fresh_d;
    logic          rd_q,    rd_d;
    logic [DW-1:0] hold_q,  hold_d;
    logic [DW-1:0] live_dat;

    // The first response cycle reads the macro directly; after that the captured copy is replayed.
    always_comb begin
        live_dat  = rd_q ? ram_dout : '0;
        rsp_valid = vld_q;
        rsp_rdata = '0;
        if (vld_q) begin
            rsp_rdata = fresh_q ? live_dat : hold_q;
        end
        free    = !vld_q || rsp_ready;
        vld_d   = grant || (vld_q && !rsp_ready);
        fresh_d = grant;
        rd_d    = grant ? grant_read : rd_q;
        hold_d  = fresh_q ? live_dat : hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            fresh_q <= 1'b0;
            rd_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            fresh_q <= fresh_d;
            rd_q    <= rd_d;
            hold_q  <= hold_d;
        end
    end
endmodule

module e203_dtcm_ram_arb #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int MW         = 4,
    parameter int STARVE_MAX = 4,
    parameter int LS_IDLE    = 16
) (
    input  logic                clk,
    input  logic                rst,
    e203_dtcm_ram_arb_if.slave  bus
);
    localparam int            IW         = $clog2(LS_IDLE);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(LS_IDLE - 1);
    localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        PWR_RUN   = 2'd0,
        PWR_SLEEP = 2'd1,
        PWR_WAKE  = 2'd2
    } pwr_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] wem;
        logic [DW-1:0] din;
    } ram_cmd_t;

    pwr_e          pwr_q,    pwr_d;
    logic [IW-1:0] idle_q,   idle_d;
    logic [7:0]    starve_q, starve_d;
    logic          ls_q,     ls_d;

    logic     a_free, b_free;
    logic     a_elig, b_elig;
    logic     run;
    logic     grant_a, grant_b;
    logic     any_vld, any_pend;
    ram_cmd_t a_cmd, b_cmd, sel_cmd;

    e203_dtcm_ram_arb_rsp_slot #(.DW(DW)) u_a_slot (
        .clk        (clk),
        .rst        (rst),
        .grant      (grant_a),
        .grant_read (bus.a_cmd_read),
        .ram_dout   (bus.ram_dout),
        .rsp_ready  (bus.a_rsp_ready),
        .rsp_valid  (bus.a_rsp_valid),
        .rsp_rdata  (bus.a_rsp_rdata),
        .free       (a_free)
    );

    e203_dtcm_ram_arb_rsp_slot #(.DW(DW)) u_b_slot (
        .clk        (clk),
        .rst        (rst),
        .grant      (grant_b),
        .grant_read (bus.b_cmd_read),
        .ram_dout   (bus.ram_dout),
        .rsp_ready  (bus.b_rsp_ready),
        .rsp_valid  (bus.b_rsp_valid),
        .rsp_rdata  (bus.b_rsp_rdata),
        .free       (b_free)
    );

    // Arbitration and SRAM drive; no grant is issued while reset is held.
    always_comb begin
        a_elig  = bus.a_cmd_valid && a_free;
        b_elig  = bus.b_cmd_valid && b_free;
        run     = (pwr_q == PWR_RUN) && !rst;
        grant_b = run && b_elig && (!a_elig || (starve_q == STARVE_LIM));
        grant_a = run && a_elig && !grant_b;

        a_cmd = '{we: !bus.a_cmd_read, addr: bus.a_cmd_addr, wem: bus.a_cmd_wmask, din: bus.a_cmd_wdata};
        b_cmd = '{we: !bus.b_cmd_read, addr: bus.b_cmd_addr, wem: bus.b_cmd_wmask, din: bus.b_cmd_wdata};
        sel_cmd = '0;
        if (grant_a) begin
            sel_cmd = a_cmd;
        end else if (grant_b) begin
            sel_cmd = b_cmd;
        end

        bus.a_cmd_ready = grant_a;
        bus.b_cmd_ready = grant_b;
        bus.ram_cs      = grant_a || grant_b;
        bus.ram_we      = sel_cmd.we;
        bus.ram_addr    = sel_cmd.addr;
        bus.ram_wem     = sel_cmd.wem;
        bus.ram_din     = sel_cmd.din;
        bus.ram_ls      = ls_q;
    end

    always_comb begin
        starve_d = starve_q;
        if (grant_b || !bus.b_cmd_valid) begin
            starve_d = '0;
        end else if (b_elig && grant_a && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Power sequencing: the idle counter only runs in RUN while nothing is requested or in flight.
    always_comb begin
        any_vld  = bus.a_cmd_valid || bus.b_cmd_valid;
        any_pend = bus.a_rsp_valid || bus.b_rsp_valid;
        pwr_d    = pwr_q;
        idle_d   = idle_q;
        case (pwr_q)
            PWR_RUN: begin
                if (any_vld || any_pend) begin
                    idle_d = '0;
                end else if (bus.ls_en && (idle_q == IDLE_LAST)) begin
                    pwr_d  = PWR_SLEEP;
                    idle_d = '0;
                end else if (idle_q != IDLE_LAST) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            PWR_SLEEP: begin
                if (any_vld || !bus.ls_en) begin
                    pwr_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                pwr_d = PWR_RUN;
            end
            default: begin
                pwr_d  = PWR_RUN;
                idle_d = '0;
            end
        endcase
        ls_d = (pwr_d == PWR_SLEEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_q    <= PWR_RUN;
            idle_q   <= '0;
            starve_q <= '0;
            ls_q     <= 1'b0;
        end else begin
            pwr_q    <= pwr_d;
            idle_q   <= idle_d;
            starve_q <= starve_d;
            ls_q     <= ls_d;
        end
    end
endmodule

// File: tb/tb_e203_dtcm_ram_arb.sv
// Bench for e203_dtcm_ram_arb: directed vector table, multi-cycle sleep/reset sequence, then random traffic
// against a queue-based reference model and a behavioural SRAM that returns junk on non-read cycles.
module tb_e203_dtcm_ram_arb;
    localparam int STARVE_MAX = 4;
    localparam int LS_IDLE    = 16;

    typedef struct {
        logic        rst, ls_en;
        logic        a_v, a_rd;
        logic [13:0] a_addr;
        logic [31:0] a_wd;
        logic [3:0]  a_wm;
        logic        a_rr;
        logic        b_v, b_rd;
        logic [13:0] b_addr;
        logic [31:0] b_wd;
        logic [3:0]  b_wm;
        logic        b_rr;
    } stim_t;

    typedef struct {
        logic        ardy, brdy, cs, we;
        logic [13:0] addr;
        logic [3:0]  wem;
        logic [31:0] din;
        logic        arv;
        logic [31:0] ard;
        logic        brv;
        logic [31:0] brd;
        logic        ls;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    e203_dtcm_ram_arb_if #(.AW(14), .DW(32), .MW(4)) bus ();

    e203_dtcm_ram_arb #(
        .AW(14), .DW(32), .MW(4), .STARVE_MAX(STARVE_MAX), .LS_IDLE(LS_IDLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    stim_t       cur;
    logic [31:0] sram    [0:16383];
    logic [31:0] ref_mem [0:16383];

    // Reference model state: pending responses as queues of expected read data.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          starve_m, idle_m, pw_m;   // pw_m: 0 run, 1 sleep, 2 wake

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, req);
        end
    endtask

    task automatic grants(input stim_t s, output bit ga, output bit gb);
        bit run, ea, eb;
        run = (pw_m == 0) && !s.rst;
        ea  = s.a_v && (qa.size() == 0 || s.a_rr);
        eb  = s.b_v && (qb.size() == 0 || s.b_rr);
        gb  = run && eb && (!ea || starve_m == STARVE_MAX);
        ga  = run && ea && !gb;
    endtask

    task automatic model_out(input stim_t s, output obs_t e);
        bit ga, gb;
        e = '{default: '0};
        grants(s, ga, gb);
        e.ardy = ga;
        e.brdy = gb;
        e.cs   = ga || gb;
        if (ga) begin
            e.we = !s.a_rd; e.addr = s.a_addr; e.wem = s.a_wm; e.din = s.a_wd;
        end else if (gb) begin
            e.we = !s.b_rd; e.addr = s.b_addr; e.wem = s.b_wm; e.din = s.b_wd;
        end
        e.arv = (qa.size() != 0);
        if (e.arv) e.ard = qa[0];
        e.brv = (qb.size() != 0);
        if (e.brv) e.brd = qb[0];
        e.ls = (pw_m == 1);
    endtask

    task automatic model_step(input stim_t s);
        bit ga, gb, busy;
        if (s.rst) begin
            qa.delete(); qb.delete();
            starve_m = 0; idle_m = 0; pw_m = 0;
            return;
        end
        grants(s, ga, gb);
        busy = s.a_v || s.b_v || qa.size() != 0 || qb.size() != 0;
        if (qa.size() != 0 && s.a_rr) void'(qa.pop_front());
        if (qb.size() != 0 && s.b_rr) void'(qb.pop_front());
        if (ga) begin
            qa.push_back(s.a_rd ? ref_mem[s.a_addr] : 32'h0);
            if (!s.a_rd) ref_mem[s.a_addr] = merge(ref_mem[s.a_addr], s.a_wd, s.a_wm);
        end
        if (gb) begin
            qb.push_back(s.b_rd ? ref_mem[s.b_addr] : 32'h0);
            if (!s.b_rd) ref_mem[s.b_addr] = merge(ref_mem[s.b_addr], s.b_wd, s.b_wm);
        end
        if (gb || !s.b_v) starve_m = 0;
        else if (s.b_v && (qb.size() == 0 || s.b_rr || gb) && ga && starve_m < STARVE_MAX) starve_m++;
        if (pw_m == 0) begin
            if (busy) idle_m = 0;
            else if (s.ls_en && idle_m == LS_IDLE - 1) begin pw_m = 1; idle_m = 0; end
            else if (idle_m < LS_IDLE - 1) idle_m++;
        end else if (pw_m == 1) begin
            if (s.a_v || s.b_v || !s.ls_en) pw_m = 2;
        end else begin
            pw_m = 0;
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ardy = bus.a_cmd_ready; o.brdy = bus.b_cmd_ready;
        o.cs   = bus.ram_cs;      o.we   = bus.ram_we;
        o.addr = bus.ram_addr;    o.wem  = bus.ram_wem;   o.din = bus.ram_din;
        o.arv  = bus.a_rsp_valid; o.ard  = bus.a_rsp_rdata;
        o.brv  = bus.b_rsp_valid; o.brd  = bus.b_rsp_rdata;
        o.ls   = bus.ram_ls;
        return o;
    endfunction

    task automatic cmp(obs_t o, obs_t e, bit full, int idx);
        chk("a_cmd_ready", idx, 32'(o.ardy), 32'(e.ardy));
        chk("b_cmd_ready", idx, 32'(o.brdy), 32'(e.brdy));
        chk("ram_cs",      idx, 32'(o.cs),   32'(e.cs));
        chk("ram_we",      idx, 32'(o.we),   32'(e.we));
        chk("ram_addr",    idx, 32'(o.addr), 32'(e.addr));
        chk("ram_din",     idx, o.din,       e.din);
        chk("a_rsp_valid", idx, 32'(o.arv),  32'(e.arv));
        chk("b_rsp_valid", idx, 32'(o.brv),  32'(e.brv));
        chk("ram_ls",      idx, 32'(o.ls),   32'(e.ls));
        if (full) chk("ram_wem", idx, 32'(o.wem), 32'(e.wem));
        if (e.arv) chk("a_rsp_rdata", idx, o.ard, e.ard);
        if (e.brv) chk("b_rsp_rdata", idx, o.brd, e.brd);
    endtask

    task automatic drive(input stim_t s);
        cur = s;
        rst = s.rst;
        bus.ls_en       = s.ls_en;
        bus.a_cmd_valid = s.a_v;  bus.a_cmd_read = s.a_rd; bus.a_cmd_addr = s.a_addr;
        bus.a_cmd_wdata = s.a_wd; bus.a_cmd_wmask = s.a_wm; bus.a_rsp_ready = s.a_rr;
        bus.b_cmd_valid = s.b_v;  bus.b_cmd_read = s.b_rd; bus.b_cmd_addr = s.b_addr;
        bus.b_cmd_wdata = s.b_wd; bus.b_cmd_wmask = s.b_wm; bus.b_rsp_ready = s.b_rr;
        #2;
    endtask

    // Behavioural SRAM acts on the DUT pins at the edge; non-read cycles return junk on ram_dout.
    task automatic tick();
        logic        rp;
        logic [31:0] rdat;
        rp   = bus.ram_cs && !bus.ram_we;
        rdat = sram[bus.ram_addr];
        if (bus.ram_cs && bus.ram_we) sram[bus.ram_addr] = merge(sram[bus.ram_addr], bus.ram_din, bus.ram_wem);
        model_step(cur);
        @(posedge clk);
        #1;
        bus.ram_dout = rp ? rdat : $urandom;
    endtask

    function automatic stim_t mk(logic av, logic ard, logic [13:0] aa, logic [31:0] awd, logic arr,
                                 logic bv, logic brd, logic [13:0] ba, logic [31:0] bwd, logic brr);
        stim_t s;
        s = '{default: '0};
        s.a_v = av; s.a_rd = ard; s.a_addr = aa; s.a_wd = awd; s.a_wm = 4'hF; s.a_rr = arr;
        s.b_v = bv; s.b_rd = brd; s.b_addr = ba; s.b_wd = bwd; s.b_wm = 4'hF; s.b_rr = brr;
        return s;
    endfunction

    function automatic vec_t vx(stim_t s, logic ardy, logic brdy, logic cs, logic we, logic [13:0] addr,
                                logic [31:0] din, logic arv, logic [31:0] ard, logic brv, logic [31:0] brd);
        vec_t v;
        v.s = s;
        v.e = '{ardy: ardy, brdy: brdy, cs: cs, we: we, addr: addr, wem: (cs ? 4'hF : 4'h0), din: din,
                arv: arv, ard: ard, brv: brv, brd: brd, ls: 1'b0};
        return v;
    endfunction

    function automatic stim_t rnd(bit quiet);
        stim_t s;
        s.rst    = ($urandom_range(0, 199) == 0);
        s.ls_en  = ($urandom_range(0, 39) != 0);
        s.a_v    = !quiet && ($urandom_range(0, 1) == 1);
        s.a_rd   = ($urandom_range(0, 1) == 1);
        s.a_addr = 14'($urandom_range(0, 31));
        s.a_wd   = $urandom;
        s.a_wm   = 4'($urandom_range(0, 15));
        s.a_rr   = quiet || ($urandom_range(0, 3) != 0);
        s.b_v    = !quiet && ($urandom_range(0, 1) == 1);
        s.b_rd   = ($urandom_range(0, 1) == 1);
        s.b_addr = 14'($urandom_range(0, 31));
        s.b_wd   = $urandom;
        s.b_wm   = 4'($urandom_range(0, 15));
        s.b_rr   = quiet || ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    task automatic run_vec(vec_t v, int idx);
        obs_t o;
        drive(v.s);
        o = sample();
        if (!v.s.rst) cmp(o, v.e, 1'b0, idx);
        tick();
    endtask

    vec_t  tbl[$];
    vec_t  seq[$];
    stim_t idle, rs, ab, s;
    vec_t  v;
    obs_t  o, e;

    initial begin
        for (int i = 0; i < 16384; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        bus.ram_dout = '0;
        idle = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        rs = idle; rs.rst = 1'b1;
        ab = mk(1, 1, 14'h10, 0, 1, 1, 1, 14'h20, 0, 1);

        drive(rs); tick();
        drive(rs); tick();

        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vx(mk(1, 0, 14'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 1), 1, 0, 1, 1, 14'h10, 32'hDEADBEEF, 0, 0, 0, 0));
        tbl.push_back(vx(mk(1, 1, 14'h10, 0, 1, 0, 0, 0, 0, 1), 1, 0, 1, 0, 14'h10, 0, 1, 0, 0, 0));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vx(mk(0, 0, 0, 0, 1, 1, 0, 14'h20, 32'h12345678, 1), 0, 1, 1, 1, 14'h20, 32'h12345678, 0, 0, 0, 0));
        tbl.push_back(vx(ab, 1, 0, 1, 0, 14'h10, 0, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(vx(ab, 1, 0, 1, 0, 14'h10, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(ab, 0, 1, 1, 0, 14'h20, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(ab, 1, 0, 1, 0, 14'h10, 0, 0, 0, 1, 32'h12345678));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vx(mk(1, 1, 14'h10, 0, 0, 0, 0, 0, 0, 1), 1, 0, 1, 0, 14'h10, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(vx(mk(1, 1, 14'h20, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(mk(1, 1, 14'h20, 0, 1, 0, 0, 0, 0, 1), 1, 0, 1, 0, 14'h20, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vx(ab, 1, 0, 1, 0, 14'h10, 0, 0, 0, 0, 0));
        tbl.push_back(vx(mk(0, 0, 0, 0, 1, 1, 1, 14'h20, 0, 1), 0, 1, 1, 0, 14'h20, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(vx(mk(1, 1, 14'h20, 0, 1, 0, 0, 0, 0, 1), 1, 0, 1, 0, 14'h20, 0, 0, 0, 1, 32'h12345678));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0));
        tbl.push_back(vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) run_vec(tbl[i], i);

        // B read granted, reset the next cycle, then idle into SLEEP and wake on a B request.
        seq.push_back(vx(mk(0, 0, 0, 0, 1, 1, 1, 14'h20, 0, 1), 0, 1, 1, 0, 14'h20, 0, 0, 0, 0, 0));
        seq.push_back(vx(rs, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 18; k++) begin
            v = vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.s.ls_en = 1'b1;
            v.e.ls = (k >= 16);
            seq.push_back(v);
        end
        v = vx(mk(0, 0, 0, 0, 1, 1, 1, 14'h20, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.s.ls_en = 1'b1; v.e.ls = 1'b1;
        seq.push_back(v);
        v.e.ls = 1'b0;
        seq.push_back(v);
        v = vx(v.s, 0, 1, 1, 0, 14'h20, 0, 0, 0, 0, 0);
        seq.push_back(v);
        v = vx(idle, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
        v.s.ls_en = 1'b1;
        seq.push_back(v);
        foreach (seq[i]) run_vec(seq[i], 100 + i);

        drive(rs); tick();
        for (int i = 0; i < 3000; i++) begin
            s = rnd((i % 250) >= 200);
            drive(s);
            model_out(s, e);
            o = sample();
            if (!s.rst) cmp(o, e, 1'b1, 1000 + i);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
